// File: rtl/sensor_hub_pkg.sv
// sensor_hub_pkg
// Shared definitions for the sensor hub: I2C address/data widths and the
// poll-scheduler FSM state encoding. No ports.
package sensor_hub_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin picker. Searches pending channels starting at
// last+1 and wrapping modulo NUM_CH; the first pending channel found wins.
// Ports:
//   pending  in  NUM_CH          channels waiting for service
//   last     in  clog2(NUM_CH)   most recently granted channel
//   winner   out NUM_CH          one-hot winner (0 when nothing pending)
//   win_idx  out clog2(NUM_CH)   index of the winner
//   found    out 1               a winner exists
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         pending,
  input  logic [$clog2(NUM_CH)-1:0] last,
  output logic [NUM_CH-1:0]         winner,
  output logic [$clog2(NUM_CH)-1:0] win_idx,
  output logic                      found
);

  localparam int IW = $clog2(NUM_CH);

  logic [IW-1:0] cand;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    // k = NUM_CH revisits 'last' itself, so a lone pending bit on the
    // previous owner is still served.
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IW'((int'(last) + k) % NUM_CH);
      if (!found && pending[cand]) begin
        found          = 1'b1;
        win_idx        = cand;
        winner[cand]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// i2c_poll_scheduler
// Shares one I2C master among NUM_CH sensor channels. On-demand requests and
// periodic auto-poll ticks mark channels pending; a round-robin arbiter picks
// the next owner, one read transaction is issued per grant, and each grant
// ends with exactly one result pulse (data or timeout).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   req          per-channel read request level, sampled every cycle
//   auto_en      enables auto-poll ticks every PERIOD cycles
//   addr_cfg     7-bit slave address of channel i at [7i+6:7i]
//   m_start      one-cycle start pulse to the master
//   m_addr       granted channel's address, held through the transaction
//   m_done       one-cycle completion pulse from the master
//   m_data       read byte, valid with m_done
//   grant        one-hot owner, held through ISSUE and WAIT
//   busy         high in ISSUE, WAIT, REPORT
//   rd_valid     one-cycle result pulse, with rd_ch/rd_data/rd_timeout
//   dbg_state    current FSM state
//
// Master handshake: m_start pulses for one cycle with m_addr already stable;
// the master answers with a single-cycle m_done carrying m_data. m_done is
// honoured only in WAIT; any other m_done (including a late one after a
// timeout) is dropped. There is no back-pressure on rd_valid.
module i2c_poll_scheduler
  import sensor_hub_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int PERIOD  = 1_000_000,
  parameter int TIMEOUT = 100_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req,
  input  logic                         auto_en,
  input  logic [I2C_ADDR_W*NUM_CH-1:0] addr_cfg,
  output logic                         m_start,
  output logic [I2C_ADDR_W-1:0]        m_addr,
  input  logic                         m_done,
  input  logic [I2C_DATA_W-1:0]        m_data,
  output logic [NUM_CH-1:0]            grant,
  output logic                         busy,
  output logic                         rd_valid,
  output logic [$clog2(NUM_CH)-1:0]    rd_ch,
  output logic [I2C_DATA_W-1:0]        rd_data,
  output logic                         rd_timeout,
  output state_e                       dbg_state
);

  localparam int IW = $clog2(NUM_CH);
  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);

  state_e                  state_q, state_d;
  logic [NUM_CH-1:0]       pending_q, pending_d;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic [IW-1:0]           last_q, last_d;
  logic                    m_start_q, m_start_d;
  logic [I2C_ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [NUM_CH-1:0]       grant_q, grant_d;
  logic                    busy_q, busy_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [IW-1:0]           rd_ch_q, rd_ch_d;
  logic [I2C_DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                    rd_timeout_q, rd_timeout_d;

  logic                    tick;
  logic [NUM_CH-1:0]       clr;
  logic [NUM_CH-1:0]       winner;
  logic [IW-1:0]           win_idx;
  logic                    found;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pending (pending_q),
    .last    (last_q),
    .winner  (winner),
    .win_idx (win_idx),
    .found   (found)
  );

  always_comb begin
    // Period counter: held at 0 while disabled, ticks and wraps at PERIOD-1.
    tick   = auto_en && (pcnt_q == PW'(PERIOD - 1));
    pcnt_d = (!auto_en || tick) ? '0 : pcnt_q + 1'b1;

    state_d      = state_q;
    last_d       = last_q;
    tcnt_d       = tcnt_q;
    m_start_d    = 1'b0;
    m_addr_d     = m_addr_q;
    grant_d      = grant_q;
    rd_valid_d   = 1'b0;
    rd_ch_d      = rd_ch_q;
    rd_data_d    = rd_data_q;
    rd_timeout_d = rd_timeout_q;
    clr          = '0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          clr       = winner;
          grant_d   = winner;
          last_d    = win_idx;
          m_addr_d  = addr_cfg[int'(win_idx)*I2C_ADDR_W +: I2C_ADDR_W];
          // Registered start: high during the ISSUE cycle.
          m_start_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Done wins over a simultaneous timeout expiry.
        if (m_done) begin
          rd_valid_d   = 1'b1;
          rd_ch_d      = last_q;
          rd_data_d    = m_data;
          rd_timeout_d = 1'b0;
          grant_d      = '0;
          state_d      = ST_REPORT;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          rd_valid_d   = 1'b1;
          rd_ch_d      = last_q;
          rd_data_d    = '0;
          rd_timeout_d = 1'b1;
          grant_d      = '0;
          state_d      = ST_REPORT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Set after clear so a request landing on the grant cycle re-pends.
    pending_d = (pending_q & ~clr) | req | {NUM_CH{tick}};
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      pcnt_q       <= '0;
      tcnt_q       <= '0;
      last_q       <= IW'(NUM_CH - 1);
      m_start_q    <= 1'b0;
      m_addr_q     <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_ch_q      <= '0;
      rd_data_q    <= '0;
      rd_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      pcnt_q       <= pcnt_d;
      tcnt_q       <= tcnt_d;
      last_q       <= last_d;
      m_start_q    <= m_start_d;
      m_addr_q     <= m_addr_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      rd_valid_q   <= rd_valid_d;
      rd_ch_q      <= rd_ch_d;
      rd_data_q    <= rd_data_d;
      rd_timeout_q <= rd_timeout_d;
    end
  end

  assign m_start    = m_start_q;
  assign m_addr     = m_addr_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign rd_valid   = rd_valid_q;
  assign rd_ch      = rd_ch_q;
  assign rd_data    = rd_data_q;
  assign rd_timeout = rd_timeout_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// tb_i2c_poll_scheduler
// Directed bench for i2c_poll_scheduler (NUM_CH=4, PERIOD=1000, TIMEOUT=100).
// A behavioural I2C master answers each m_start after mdl_lat cycles with a
// per-address byte. A negedge monitor compares every m_start and rd_valid
// against expected queues filled by the stimulus code.
module tb_i2c_poll_scheduler;
  import sensor_hub_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int PERIOD  = 1000;
  localparam int TIMEOUT = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NUM_CH-1:0]   req = '0;
  logic                auto_en = 1'b0;
  logic [7*NUM_CH-1:0] addr_cfg = {7'h7F, 7'h48, 7'h31, 7'h50};
  logic                m_start;
  logic [6:0]          m_addr;
  logic                m_done = 1'b0;
  logic [7:0]          m_data = 8'h5A;
  logic [NUM_CH-1:0]   grant;
  logic                busy;
  logic                rd_valid;
  logic [1:0]          rd_ch;
  logic [7:0]          rd_data;
  logic                rd_timeout;
  state_e              dbg_state;

  i2c_poll_scheduler #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .auto_en(auto_en), .addr_cfg(addr_cfg),
    .m_start(m_start), .m_addr(m_addr), .m_done(m_done), .m_data(m_data),
    .grant(grant), .busy(busy), .rd_valid(rd_valid), .rd_ch(rd_ch),
    .rd_data(rd_data), .rd_timeout(rd_timeout), .dbg_state(dbg_state)
  );

  // Per-channel address (matches addr_cfg) and the byte the master returns.
  logic [6:0] addr_tbl [NUM_CH] = '{7'h50, 7'h31, 7'h48, 7'h7F};
  logic [7:0] data_tbl [NUM_CH] = '{8'hA0, 8'h11, 8'd25, 8'h3C};

  // ---------------- master model ----------------
  int         mdl_lat = 5;
  bit         mdl_never = 1'b0;
  bit         mdl_armed = 1'b0;
  int         mdl_rem = 0;
  logic [7:0] mdl_dat = '0;
  int         done_cyc = 0;

  always @(posedge clk) begin
    #2;
    m_done = 1'b0;
    m_data = 8'h5A;
    if (rst) begin
      mdl_armed = 1'b0;
    end else if (m_start) begin
      mdl_armed = !mdl_never;
      mdl_rem   = mdl_lat;
      mdl_dat   = 8'hEE;
      for (int i = 0; i < NUM_CH; i++) if (addr_tbl[i] == m_addr) mdl_dat = data_tbl[i];
    end else if (mdl_armed) begin
      mdl_rem--;
      if (mdl_rem == 0) begin
        m_done    = 1'b1;
        m_data    = mdl_dat;
        mdl_armed = 1'b0;
        done_cyc  = cyc;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [10:0] start_q [$];   // {grant, m_addr}
  logic [10:0] exp_q [$];     // {rd_timeout, rd_ch, rd_data}
  logic [10:0] mon_s, mon_e;
  int          mon_exp_cyc;
  int          last_start_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_start) begin
        checks++;
        last_start_cyc = cyc;
        if (start_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_start grant=%b addr=%h required none", grant, m_addr);
        end else begin
          mon_s = start_q.pop_front();
          if ({grant, m_addr} !== mon_s) begin
            errors++;
            $display("FAIL start grant=%b addr=%h required grant=%b addr=%h",
                     grant, m_addr, mon_s[10:7], mon_s[6:0]);
          end
        end
      end
      if (rd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result ch=%0d data=%h to=%b required none", rd_ch, rd_data, rd_timeout);
        end else begin
          mon_e = exp_q.pop_front();
          if ({rd_timeout, rd_ch, rd_data} !== mon_e) begin
            errors++;
            $display("FAIL result to=%b ch=%0d data=%h required to=%b ch=%0d data=%h",
                     rd_timeout, rd_ch, rd_data, mon_e[10], mon_e[9:8], mon_e[7:0]);
          end
          // Timeout: 1 ISSUE cycle + TIMEOUT WAIT cycles after m_start.
          mon_exp_cyc = mon_e[10] ? last_start_cyc + TIMEOUT + 1 : done_cyc + 1;
          checks++;
          if (cyc != mon_exp_cyc) begin
            errors++;
            $display("FAIL result_cycle actual=%0d required=%0d", cyc, mon_exp_cyc);
          end
          checks++;
          if (grant !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL report_flags grant=%b busy=%b required grant=0000 busy=1", grant, busy);
          end
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic expect_txn(input int ch, input bit to);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    start_q.push_back({oh, addr_tbl[ch]});
    exp_q.push_back({to, 2'(ch), to ? 8'h00 : data_tbl[ch]});
  endtask

  // Drive req for 'len' cycles; returns the cycle of the first one.
  task automatic pulse_req(input logic [3:0] v, input int len, output int t);
    @(posedge clk); #1;
    req = v;
    t = cyc;
    repeat (len) @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic wait_start(input int budget, output int t);
    int n = 0;
    t = -1;
    do begin @(negedge clk); n++; end while (!m_start && n < budget);
    if (m_start) t = cyc;
    else begin
      checks++;
      errors++;
      $display("FAIL start_wait actual=none required=m_start within %0d cycles", budget);
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || start_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || start_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain outstanding results=%0d starts=%0d required 0", tag, exp_q.size(), start_q.size());
      exp_q.delete();
      start_q.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_start"}, 32'(m_start), 0);
    chk({tag, "_m_addr"}, 32'(m_addr), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_ch"}, 32'(rd_ch), 0);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_rd_timeout"}, 32'(rd_timeout), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] req;
    int         lat;
    bit         never;
    logic [3:0] exp_grant;
    logic [6:0] exp_addr;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
    bit         exp_to;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t_req, c0, c1, n_out;

    vecs[0] = '{4'b0100,  50, 1'b0, 4'b0100, 7'h48, 2'd2, 8'd25, 1'b0};
    vecs[1] = '{4'b0001,   1, 1'b0, 4'b0001, 7'h50, 2'd0, 8'hA0, 1'b0};
    vecs[2] = '{4'b0010, 100, 1'b0, 4'b0010, 7'h31, 2'd1, 8'h11, 1'b0}; // done on expiry cycle
    vecs[3] = '{4'b1000, 101, 1'b0, 4'b1000, 7'h7F, 2'd3, 8'h00, 1'b1}; // one cycle late
    vecs[4] = '{4'b0100,   0, 1'b1, 4'b0100, 7'h48, 2'd2, 8'h00, 1'b1}; // never answers
    vecs[5] = '{4'b1000,   7, 1'b0, 4'b1000, 7'h7F, 2'd3, 8'h3C, 1'b0};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");

    // Single-channel transactions.
    for (int i = 0; i < 6; i++) begin
      mdl_lat   = vecs[i].lat;
      mdl_never = vecs[i].never;
      start_q.push_back({vecs[i].exp_grant, vecs[i].exp_addr});
      exp_q.push_back({vecs[i].exp_to, vecs[i].exp_ch, vecs[i].exp_data});
      pulse_req(vecs[i].req, 1, t_req);
      wait_start(10, t);
      chk("vec_start_latency", t, t_req + 2);
      chk("vec_busy_at_start", 32'(busy), 1);
      drain(300, "vec");
    end
    mdl_never = 1'b0;

    // Contention: all four once, in order, with a redundant req[2] absorbed.
    do_reset();
    mdl_lat = 3;
    for (int c = 0; c < 4; c++) expect_txn(c, 1'b0);
    pulse_req(4'b1111, 1, t_req);
    repeat (2) @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk);
    #1 req = '0;
    drain(200, "contention");

    // ch0 then ch3.
    expect_txn(0, 1'b0);
    expect_txn(3, 1'b0);
    pulse_req(4'b0001, 1, t_req);
    repeat (2) @(posedge clk);
    #1 req = 4'b1000;
    @(posedge clk);
    #1 req = '0;
    drain(200, "ch0_ch3");

    // Late done after a timeout must not produce a second result.
    mdl_lat = 150;
    expect_txn(1, 1'b1);
    pulse_req(4'b0010, 1, t_req);
    drain(300, "late_done");
    repeat (60) @(negedge clk);
    chk("late_done_queue_empty", 32'(exp_q.size()), 0);

    // Auto-poll: first tick at counter 999.
    do_reset();
    mdl_lat = 5;
    for (int c = 0; c < 4; c++) expect_txn(c, 1'b0);
    @(posedge clk); #1;
    auto_en = 1'b1;
    c0 = cyc;
    wait_start(1100, t);
    chk("auto_first_start", t, c0 + PERIOD + 1);
    drain(200, "auto1");
    // One-cycle disable restarts the count from 0.
    for (int c = 0; c < 4; c++) expect_txn(c, 1'b0);
    @(posedge clk); #1;
    auto_en = 1'b0;
    c1 = cyc;
    @(posedge clk); #1;
    auto_en = 1'b1;
    wait_start(1100, t);
    chk("auto_restart_start", t, c1 + PERIOD + 2);
    drain(200, "auto2");
    auto_en = 1'b0;

    // Re-pend race: req[1] still high on ch1's grant cycle.
    do_reset();
    mdl_lat = 1;
    expect_txn(1, 1'b0);
    expect_txn(1, 1'b0);
    pulse_req(4'b0010, 2, t_req);
    wait_start(10, t);
    chk("race_first_start", t, t_req + 2);
    wait_start(20, t2);
    // done at t+1, REPORT t+2, IDLE t+3, ISSUE t+4.
    chk("race_second_start", t2, t + 4);
    drain(100, "race");

    // Reset during WAIT: aborts, drops the pending ch3, rewinds last.
    do_reset();
    mdl_lat = 60;
    start_q.push_back({4'b0100, 7'h48});
    pulse_req(4'b0100, 1, t_req);
    wait_start(10, t);
    pulse_req(4'b1000, 1, t_req);
    repeat (4) @(posedge clk);
    chk("midrst_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    do_reset();
    check_reset_outputs("midrst");
    n_out = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rd_valid || m_start) n_out++;
    end
    chk("midrst_silent", n_out, 0);
    mdl_lat = 6;
    expect_txn(0, 1'b0);
    expect_txn(3, 1'b0);
    pulse_req(4'b1001, 1, t_req);
    wait_start(10, t);
    chk("midrst_next_start", t, t_req + 2);
    drain(200, "midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
